// File: rtl/bpu_pkg.sv
`default_nettype none
// ============================================================================
// bpu_pkg : shared branch-type, counter and link-offset definitions
// Rev 1.0
// ============================================================================
package bpu_pkg;

  typedef enum logic [1:0] {
    BT_COND = 2'd0,
    BT_JMP  = 2'd1,
    BT_CALL = 2'd2,
    BT_RET  = 2'd3
  } br_type_e;

  localparam logic [1:0] CNT_SNT = 2'd0;
  localparam logic [1:0] CNT_WNT = 2'd1;
  localparam logic [1:0] CNT_WT  = 2'd2;
  localparam logic [1:0] CNT_ST  = 2'd3;

  // Return address skips the call and its delay slot.
  localparam logic [31:0] PC_LINK_OFS = 32'd8;

  function automatic logic [1:0] cnt_train(input logic [1:0] cnt, input logic tkn);
    if (tkn) return (cnt == CNT_ST) ? CNT_ST : cnt + 2'd1;
    else return (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bpu_ras.sv
`default_nettype none
// ============================================================================
// bpu_ras : circular return-address stack, compiled only with BPU_RAS_EN
// Rev 1.0
// ============================================================================
`ifdef BPU_RAS_EN
module bpu_ras
  import bpu_pkg::*;
#(
  parameter int RAS_DEPTH = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  logic [31:0] push_addr,
  output logic [31:0] top_addr,
  output logic        top_valid
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  logic [31:0]      stack_q [RAS_DEPTH];
  logic [31:0]      stack_d [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] top_ptr;

  // ptr_q names the next free slot, so the top lives one below it.
  assign top_ptr   = ptr_q - PTR_W'(1);
  assign top_addr  = stack_q[top_ptr];
  assign top_valid = (count_q != '0);

  always_comb begin
    stack_d = stack_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (push) begin
      stack_d[ptr_q] = push_addr;
      ptr_d          = ptr_q + PTR_W'(1);
      if (count_q != CNT_MAX) count_d = count_q + CNT_W'(1);
    end else if (pop && top_valid) begin
      ptr_d   = top_ptr;
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < RAS_DEPTH; i++) stack_q[i] <= '0;
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      stack_q <= stack_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

endmodule
`endif
`default_nettype wire

// File: rtl/bpu_btb_bht.sv
`default_nettype none
// ============================================================================
// bpu_btb_bht : direct-mapped BTB with 2-bit BHT; define BPU_RAS_EN for a return stack
// Rev 1.0
// ============================================================================
module bpu_btb_bht
  import bpu_pkg::*;
#(
  parameter int ENTRIES   = 64,
  parameter int TAG_W     = 10,
  parameter int RAS_DEPTH = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        lk_valid,
  input  logic [31:0] lk_pc,
  output logic        taken,
  output logic [31:0] pc_predict,
  output logic        pred_hit,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic [1:0]  upd_type,
  input  logic        ras_flush
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_HI = IDX_W + TAG_W + 1;

  logic             valid_q  [ENTRIES];
  logic             valid_d  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [TAG_W-1:0] tag_d    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [31:0]      target_d [ENTRIES];
  br_type_e         type_q   [ENTRIES];
  br_type_e         type_d   [ENTRIES];
  logic [1:0]       cnt_q    [ENTRIES];
  logic [1:0]       cnt_d    [ENTRIES];

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             lk_hit, upd_hit;
  br_type_e         lk_type;

  assign lk_idx  = lk_pc[IDX_W+1:2];
  assign lk_tag  = lk_pc[TAG_HI:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[TAG_HI:IDX_W+2];

  assign lk_hit  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign lk_type = type_q[lk_idx];

  // Only conditional branches consult the counter; jumps/calls/returns always redirect.
  assign pred_hit = lk_valid && lk_hit;
  assign taken    = pred_hit && ((lk_type != BT_COND) || cnt_q[lk_idx][1]);

`ifdef BPU_RAS_EN
  logic        ras_push, ras_pop, ras_top_valid;
  logic [31:0] ras_top;

  assign ras_push = pred_hit && (lk_type == BT_CALL);
  assign ras_pop  = pred_hit && (lk_type == BT_RET);

  bpu_ras #(
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .resetn    (resetn),
    .push      (ras_push),
    .pop       (ras_pop),
    .flush     (ras_flush),
    .push_addr (lk_pc + PC_LINK_OFS),
    .top_addr  (ras_top),
    .top_valid (ras_top_valid)
  );
`else
  logic unused_ras_flush;
  assign unused_ras_flush = ras_flush;
`endif

  always_comb begin
    pc_predict = lk_pc + 32'd4;
    if (taken) pc_predict = target_q[lk_idx];
`ifdef BPU_RAS_EN
    // An empty stack leaves the BTB target in place.
    if (ras_pop && ras_top_valid) pc_predict = ras_top;
`endif
  end

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    type_d   = type_q;
    cnt_d    = cnt_q;
    if (upd_valid) begin
      if (upd_hit) begin
        cnt_d[upd_idx] = cnt_train(cnt_q[upd_idx], upd_taken);
        if (upd_taken) begin
          target_d[upd_idx] = upd_target;
          type_d[upd_idx]   = br_type_e'(upd_type);
        end
      end else if (upd_taken) begin
        valid_d[upd_idx]  = 1'b1;
        tag_d[upd_idx]    = upd_tag;
        target_d[upd_idx] = upd_target;
        type_d[upd_idx]   = br_type_e'(upd_type);
        cnt_d[upd_idx]    = CNT_WT;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        type_q[i]   <= BT_COND;
        cnt_q[i]    <= CNT_WNT;
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      type_q   <= type_d;
      cnt_q    <= cnt_d;
    end
  end

  logic unused_pc_bits;
  assign unused_pc_bits = ^{upd_pc[1:0], upd_pc[31:TAG_HI+1]};

endmodule
`default_nettype wire

// File: tb/tb_bpu_btb_bht.sv
`default_nettype none
// ============================================================================
// tb_bpu_btb_bht : scoreboard bench with a table-level reference predictor
// Rev 1.0
// ============================================================================
module tb_bpu_btb_bht;

  localparam int ENTRIES   = 64;
  localparam int IDX_W     = 6;
  localparam int TAG_W     = 10;
  localparam int RAS_DEPTH = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        lk_valid = 1'b0;
  logic [31:0] lk_pc = '0;
  logic        taken;
  logic [31:0] pc_predict;
  logic        pred_hit;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic [1:0]  upd_type = '0;
  logic        ras_flush = 1'b0;

  always #5 clk = ~clk;

  bpu_btb_bht #(
    .ENTRIES   (ENTRIES),
    .TAG_W     (TAG_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .lk_valid   (lk_valid),
    .lk_pc      (lk_pc),
    .taken      (taken),
    .pc_predict (pc_predict),
    .pred_hit   (pred_hit),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_taken  (upd_taken),
    .upd_target (upd_target),
    .upd_type   (upd_type),
    .ras_flush  (ras_flush)
  );

  typedef struct {
    logic        tkn;
    logic [31:0] npc;
    logic        hit;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference predictor: one record per table slot, plus a list-based return stack.
  bit          m_valid [ENTRIES];
  int unsigned m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_type  [ENTRIES];
  int          m_cnt   [ENTRIES];
  logic [31:0] m_ras[$];

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return (pc >> (2 + IDX_W)) % (32'd1 << TAG_W);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = '0; m_type[i] = 0; m_cnt[i] = 1;
    end
    m_ras.delete();
  endtask

  task automatic predict(input bit lkv, input logic [31:0] pc, output exp_t e);
    int  i;
    bit  h;
    i = idx_of(pc);
    h = lkv && m_hit(pc);
    e.hit = h;
    e.tkn = h && (m_type[i] != 0 || m_cnt[i] >= 2);
    e.npc = e.tkn ? m_tgt[i] : pc + 32'd4;
`ifdef BPU_RAS_EN
    if (h && m_type[i] == 3 && m_ras.size() > 0) e.npc = m_ras[$];
`endif
  endtask

  task automatic model_edge(input bit lkv, input logic [31:0] lpc, input bit uv,
                            input logic [31:0] upc, input bit ut, input logic [31:0] utgt,
                            input int uty, input bit fl);
    int j;
`ifdef BPU_RAS_EN
    bit h;
    h = lkv && m_hit(lpc);
    if (fl) m_ras.delete();
    else if (h && m_type[idx_of(lpc)] == 2) begin
      m_ras.push_back(lpc + 32'd8);
      if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
    end else if (h && m_type[idx_of(lpc)] == 3 && m_ras.size() > 0) void'(m_ras.pop_back());
`endif
    if (uv) begin
      j = idx_of(upc);
      if (m_hit(upc)) begin
        if (ut) m_cnt[j] = (m_cnt[j] < 3) ? m_cnt[j] + 1 : 3;
        else    m_cnt[j] = (m_cnt[j] > 0) ? m_cnt[j] - 1 : 0;
        if (ut) begin m_tgt[j] = utgt; m_type[j] = uty; end
      end else if (ut) begin
        m_valid[j] = 1; m_tag[j] = tag_of(upc); m_tgt[j] = utgt; m_type[j] = uty; m_cnt[j] = 2;
      end
    end
  endtask

  task automatic cyc(input bit lkv, input logic [31:0] lpc, input bit uv = 0,
                     input logic [31:0] upc = 0, input bit ut = 0,
                     input logic [31:0] utgt = 0, input int uty = 0, input bit fl = 0);
    exp_t e;
    @(posedge clk);
    #1;
    lk_valid = lkv; lk_pc = lpc; upd_valid = uv; upd_pc = upc; upd_taken = ut;
    upd_target = utgt; upd_type = 2'(uty); ras_flush = fl;
    predict(lkv, lpc, e);
    sb_q.push_back(e);
    model_edge(lkv, lpc, uv, upc, ut, utgt, uty, fl);
  endtask

  // Reset is asserted between edges so the next sample only passes if it acts asynchronously.
  task automatic async_reset();
    exp_t e;
    @(posedge clk);
    #1;
    resetn = 1'b0; lk_valid = 1'b1; lk_pc = 32'hBFC00000; upd_valid = 1'b0; ras_flush = 1'b0;
    model_reset();
    predict(1'b1, lk_pc, e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    sb_q.push_back(e);
    resetn = 1'b1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h lk_pc=%h t=%0t", name, act, req, lk_pc, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("taken", 32'(taken), 32'(e.tkn));
        chk("pred_hit", 32'(pred_hit), 32'(e.hit));
        chk("pc_predict", pc_predict, e.npc);
      end
    end
  end

  logic [31:0] pool [12] = '{32'h80000100, 32'h80010100, 32'h80020100, 32'h80000104,
                             32'h80000108, 32'h80000200, 32'h80040200, 32'h80001000,
                             32'h80000010, 32'h80000520, 32'h800000F0, 32'hFFFFFFFC};

  initial begin : stim
    logic [31:0] lp, up;
    model_reset();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    cyc(1, 32'hBFC00000);
    // Conditional branch: allocate weakly taken, then train down to strongly not-taken.
    cyc(0, 0, 1, 32'h80001000, 1, 32'h80002000, 0);
    cyc(1, 32'h80001000);
    cyc(0, 0, 1, 32'h80001000, 0, 0, 0);
    cyc(0, 0, 1, 32'h80001000, 0, 0, 0);
    cyc(1, 32'h80001000);
    cyc(0, 0, 1, 32'h80001000, 0, 0, 0);
    cyc(1, 32'h80001000);
    repeat (4) cyc(0, 0, 1, 32'h80001000, 1, 32'h80002000, 0);
    cyc(0, 0, 1, 32'h80001000, 0, 0, 0);
    cyc(1, 32'h80001000);
    // Aliasing on index 0 with a different tag.
    cyc(0, 0, 1, 32'h80000100, 1, 32'h80000900, 0);
    cyc(1, 32'h80000100);
    cyc(0, 0, 1, 32'h80010100, 1, 32'h80000A00, 1);
    cyc(1, 32'h80000100);
    cyc(1, 32'h80010100);
    cyc(0, 0, 1, 32'h80000200, 0, 32'h11111110, 0);
    cyc(1, 32'h80000200);
    // Same-cycle update and lookup.
    cyc(1, 32'h80003000, 1, 32'h80003000, 1, 32'h80004000, 1);
    cyc(1, 32'h80003000);
    cyc(0, 32'h80003000);
    cyc(1, 32'hFFFFFFFC);
    // Type-1 entry keeps predicting taken even when its counter trains to zero.
    repeat (3) cyc(0, 0, 1, 32'h80003000, 0, 0, 0);
    cyc(1, 32'h80003000);

`ifdef BPU_RAS_EN
    cyc(0, 0, 1, 32'h80000010, 1, 32'h80000400, 2, 1);
    cyc(0, 0, 1, 32'h80000520, 1, 32'h80000600, 3);
    cyc(1, 32'h80000010);
    cyc(1, 32'h80000520);
    repeat (5) cyc(1, 32'h80000010);
    repeat (5) cyc(1, 32'h80000520);
    cyc(1, 32'h80000010);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 32'h80000520);
    cyc(1, 32'h80000010, 0, 0, 0, 0, 0, 1);
    cyc(1, 32'h80000520);
`endif

    for (int n = 0; n < 400; n++) begin
      lp = pool[$urandom_range(0, 11)];
      up = pool[$urandom_range(0, 11)];
      cyc(($urandom_range(0, 3) != 0), lp, ($urandom_range(0, 1) == 1), up,
          ($urandom_range(0, 2) != 0), {$urandom_range(0, 32'h3FFFFFFF), 2'b00},
          int'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0));
    end

    cyc(0, 0, 1, 32'hBFC00000, 1, 32'h12345678, 1);
    cyc(1, 32'hBFC00000);
    async_reset();
    cyc(1, 32'hBFC00000);
    cyc(1, 32'h80001000);
    cyc(0, 0);

    for (int k = 0; k < 10; k++) begin
      if (sb_q.size() == 0) break;
      @(negedge clk);
      #1;
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
